// File: rtl/generic_vidtopid_tbl.sv
// Rebuildable virtual-ID to physical-ID hart map with scalar lookup ports and a
// bit-vector translator. The table is indexed by VID and is filled by a one-entry-per-cycle scan.
module generic_vidtopid_tbl #(
  parameter int unsigned NumHarts     = 8,
  parameter int unsigned NumHartsIdx  = (NumHarts == 1) ? 1 : $clog2(NumHarts),
  parameter int unsigned NumLkupPorts = 2
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                rebuild_req,
  input  logic [NumHarts-1:0]                 fuse_map,
  input  logic [NumHarts*NumHartsIdx-1:0]     vid_map,
  output logic                                busy,
  output logic                                tbl_valid,
  output logic                                map_err,
  output logic [NumHartsIdx-1:0]              err_vid,
  input  logic [NumLkupPorts-1:0]             lkup_vld,
  input  logic [NumLkupPorts*NumHartsIdx-1:0] lkup_vid,
  output logic                                lkup_rdy,
  output logic [NumLkupPorts-1:0]             rsp_vld,
  output logic [NumLkupPorts*NumHartsIdx-1:0] rsp_pid,
  output logic [NumLkupPorts-1:0]             rsp_mapped,
  input  logic                                vec_vld,
  input  logic [NumHarts-1:0]                 vid_vector,
  output logic                                pid_vec_vld,
  output logic [NumHarts-1:0]                 pid_vector
);

  localparam logic [NumHartsIdx-1:0] LastIdx = NumHartsIdx'(NumHarts - 1);

  typedef enum logic [1:0] {StEmpty, StScan, StReady} state_e;

  state_e                   state_q;
  logic [NumHartsIdx-1:0]   cnt_q;
  logic [NumHarts-1:0]      snap_fuse_q;
  logic [NumHartsIdx-1:0]   snap_vid_q [NumHarts];
  logic [NumHarts-1:0]      tbl_mapped_q;
  logic [NumHartsIdx-1:0]   tbl_pid_q [NumHarts];
  logic                     map_err_q;
  logic [NumHartsIdx-1:0]   err_vid_q;

  logic [NumLkupPorts-1:0]             rsp_vld_q;
  logic [NumLkupPorts*NumHartsIdx-1:0] rsp_pid_q;
  logic [NumLkupPorts-1:0]             rsp_mapped_q;
  logic                                pid_vec_vld_q;
  logic [NumHarts-1:0]                 pid_vector_q;

  logic                   cur_fuse;
  logic [NumHartsIdx-1:0] cur_vid;
  logic [NumHarts-1:0]    pid_vec_d;

  assign cur_fuse = snap_fuse_q[cnt_q];
  assign cur_vid  = snap_vid_q[cnt_q];

  // Build state: a rebuild request wins over any scan step in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StEmpty;
      cnt_q        <= '0;
      snap_fuse_q  <= '0;
      tbl_mapped_q <= '0;
      map_err_q    <= 1'b0;
      err_vid_q    <= '0;
      for (int i = 0; i < NumHarts; i++) begin
        snap_vid_q[i] <= '0;
        tbl_pid_q[i]  <= '0;
      end
    end else if (rebuild_req) begin
      state_q      <= StScan;
      cnt_q        <= '0;
      snap_fuse_q  <= fuse_map;
      tbl_mapped_q <= '0;
      map_err_q    <= 1'b0;
      err_vid_q    <= '0;
      for (int i = 0; i < NumHarts; i++) begin
        snap_vid_q[i] <= vid_map[i*NumHartsIdx +: NumHartsIdx];
        tbl_pid_q[i]  <= '0;
      end
    end else if (state_q == StScan) begin
      if (cur_fuse) begin
        if (!tbl_mapped_q[cur_vid]) begin
          tbl_mapped_q[cur_vid] <= 1'b1;
          tbl_pid_q[cur_vid]    <= cnt_q;
        end else if (!map_err_q) begin
          // Lower-numbered hart keeps the VID; only the first clash is reported.
          map_err_q <= 1'b1;
          err_vid_q <= cur_vid;
        end
      end
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LastIdx) begin
        state_q <= StReady;
      end
    end
  end

  always_comb begin
    pid_vec_d = '0;
    for (int v = 0; v < NumHarts; v++) begin
      if (tbl_mapped_q[v]) begin
        pid_vec_d[tbl_pid_q[v]] = vid_vector[v];
      end
    end
  end

  // Responses sample the table before any same-cycle rebuild clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_vld_q     <= '0;
      rsp_pid_q     <= '0;
      rsp_mapped_q  <= '0;
      pid_vec_vld_q <= 1'b0;
      pid_vector_q  <= '0;
    end else begin
      for (int k = 0; k < NumLkupPorts; k++) begin
        rsp_vld_q[k] <= lkup_vld[k] & lkup_rdy;
        if (lkup_vld[k] && lkup_rdy) begin
          rsp_pid_q[k*NumHartsIdx +: NumHartsIdx] <=
              tbl_pid_q[lkup_vid[k*NumHartsIdx +: NumHartsIdx]];
          rsp_mapped_q[k] <= tbl_mapped_q[lkup_vid[k*NumHartsIdx +: NumHartsIdx]];
        end
      end
      pid_vec_vld_q <= vec_vld & lkup_rdy;
      if (vec_vld && lkup_rdy) begin
        pid_vector_q <= pid_vec_d;
      end
    end
  end

  assign busy        = (state_q == StScan);
  assign tbl_valid   = (state_q == StReady);
  assign lkup_rdy    = tbl_valid;
  assign map_err     = map_err_q;
  assign err_vid     = err_vid_q;
  assign rsp_vld     = rsp_vld_q;
  assign rsp_pid     = rsp_pid_q;
  assign rsp_mapped  = rsp_mapped_q;
  assign pid_vec_vld = pid_vec_vld_q;
  assign pid_vector  = pid_vector_q;

endmodule

// File: tb/tb_generic_vidtopid_tbl.sv
// Bench for generic_vidtopid_tbl: directed scenarios plus randomized traffic, all
// checked every cycle against a whole-map reference model.
module tb_generic_vidtopid_tbl;

  localparam int N = 8;
  localparam int W = 3;
  localparam int P = 2;

  logic           clk = 1'b0;
  logic           reset_n = 1'b1;
  logic           rebuild_req = 1'b0;
  logic [N-1:0]   fuse_map = '0;
  logic [N*W-1:0] vid_map = '0;
  logic           busy, tbl_valid, map_err;
  logic [W-1:0]   err_vid;
  logic [P-1:0]   lkup_vld = '0;
  logic [P*W-1:0] lkup_vid = '0;
  logic           lkup_rdy;
  logic [P-1:0]   rsp_vld;
  logic [P*W-1:0] rsp_pid;
  logic [P-1:0]   rsp_mapped;
  logic           vec_vld = 1'b0;
  logic [N-1:0]   vid_vector = '0;
  logic           pid_vec_vld;
  logic [N-1:0]   pid_vector;

  generic_vidtopid_tbl #(.NumHarts(N), .NumLkupPorts(P)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rebuild_req (rebuild_req),
    .fuse_map    (fuse_map),
    .vid_map     (vid_map),
    .busy        (busy),
    .tbl_valid   (tbl_valid),
    .map_err     (map_err),
    .err_vid     (err_vid),
    .lkup_vld    (lkup_vld),
    .lkup_vid    (lkup_vid),
    .lkup_rdy    (lkup_rdy),
    .rsp_vld     (rsp_vld),
    .rsp_pid     (rsp_pid),
    .rsp_mapped  (rsp_mapped),
    .vec_vld     (vec_vld),
    .vid_vector  (vid_vector),
    .pid_vec_vld (pid_vec_vld),
    .pid_vector  (pid_vector)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: the final map is computed in one go from the snapshot.
  bit m_scan, m_ready;
  int m_n;
  bit m_mapped [N];
  int m_pid [N];
  bit m_dup;
  int m_err_p, m_err_vid;
  bit m_rsp_vld [P];
  int m_rsp_pid [P];
  bit m_rsp_mapped [P];
  bit m_pvv;
  int m_pv;

  function automatic int vid_of(input logic [N*W-1:0] vm, input int p);
    return int'(vm[p*W +: W]);
  endfunction

  task automatic model_build(input logic [N-1:0] f, input logic [N*W-1:0] vm);
    for (int v = 0; v < N; v++) begin
      m_mapped[v] = 1'b0;
      m_pid[v] = 0;
      for (int p = N - 1; p >= 0; p--) begin
        if (f[p] && vid_of(vm, p) == v) begin
          m_mapped[v] = 1'b1;
          m_pid[v] = p;
        end
      end
    end
    m_dup = 1'b0;
    m_err_p = 0;
    m_err_vid = 0;
    for (int p = 0; p < N; p++) begin
      for (int q = 0; q < p; q++) begin
        if (!m_dup && f[p] && f[q] && vid_of(vm, q) == vid_of(vm, p)) begin
          m_dup = 1'b1;
          m_err_p = p;
          m_err_vid = vid_of(vm, p);
        end
      end
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_scan = 0; m_ready = 0; m_n = 0; m_dup = 0; m_err_p = 0; m_err_vid = 0;
      m_pvv = 0; m_pv = 0;
      for (int v = 0; v < N; v++) begin m_mapped[v] = 0; m_pid[v] = 0; end
      for (int k = 0; k < P; k++) begin
        m_rsp_vld[k] = 0; m_rsp_pid[k] = 0; m_rsp_mapped[k] = 0;
      end
    end else begin
      for (int k = 0; k < P; k++) begin
        m_rsp_vld[k] = lkup_vld[k] && m_ready;
        if (m_rsp_vld[k]) begin
          m_rsp_mapped[k] = m_mapped[int'(lkup_vid[k*W +: W])];
          m_rsp_pid[k] = m_rsp_mapped[k] ? m_pid[int'(lkup_vid[k*W +: W])] : 0;
        end
      end
      m_pvv = vec_vld && m_ready;
      if (m_pvv) begin
        m_pv = 0;
        for (int v = 0; v < N; v++)
          if (m_mapped[v] && vid_vector[v]) m_pv = m_pv | (1 << m_pid[v]);
      end
      if (rebuild_req) begin
        model_build(fuse_map, vid_map);
        m_scan = 1; m_ready = 0; m_n = 0;
      end else if (m_scan) begin
        m_n++;
        if (m_n == N) begin m_scan = 0; m_ready = 1; end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      bit exp_err;
      exp_err = m_dup && (m_n > m_err_p);
      chk("busy", 32'(busy), 32'(m_scan));
      chk("tbl_valid", 32'(tbl_valid), 32'(m_ready));
      chk("lkup_rdy", 32'(lkup_rdy), 32'(m_ready));
      chk("map_err", 32'(map_err), 32'(exp_err));
      chk("err_vid", 32'(err_vid), exp_err ? m_err_vid : 0);
      for (int k = 0; k < P; k++) begin
        chk("rsp_vld", 32'(rsp_vld[k]), 32'(m_rsp_vld[k]));
        chk("rsp_pid", 32'(rsp_pid[k*W +: W]), m_rsp_pid[k]);
        chk("rsp_mapped", 32'(rsp_mapped[k]), 32'(m_rsp_mapped[k]));
      end
      chk("pid_vec_vld", 32'(pid_vec_vld), 32'(m_pvv));
      chk("pid_vector", 32'(pid_vector), m_pv);
    end
  end

  function automatic logic [N*W-1:0] ident_map();
    logic [N*W-1:0] vm;
    for (int p = 0; p < N; p++) vm[p*W +: W] = W'(p);
    return vm;
  endfunction

  task automatic rebuild(input logic [N-1:0] f, input logic [N*W-1:0] vm, output int nbusy);
    @(negedge clk);
    fuse_map = f; vid_map = vm; rebuild_req = 1'b1;
    @(negedge clk);
    rebuild_req = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 40 && !tbl_valid; i++) begin
      if (busy) nbusy++;
      @(negedge clk);
    end
    chk("rebuild_done", 32'(tbl_valid), 1);
  endtask

  task automatic lookup(input int port, input int vid, input int ep, input int em);
    @(negedge clk);
    lkup_vld = '0;
    lkup_vld[port] = 1'b1;
    lkup_vid[port*W +: W] = W'(vid);
    @(negedge clk);
    lkup_vld = '0;
    #1;
    chk("lit_rsp_vld", 32'(rsp_vld[port]), 1);
    chk("lit_rsp_pid", 32'(rsp_pid[port*W +: W]), ep);
    chk("lit_rsp_mapped", 32'(rsp_mapped[port]), em);
  endtask

  initial begin
    int nb;
    logic [N*W-1:0] perm, dupm;
    perm = '0;
    for (int p = 0; p < 4; p++) perm[p*W +: W] = W'(3 - p);
    dupm = ident_map();
    dupm[2*W +: W] = 3'd4; dupm[4*W +: W] = 3'd2;
    dupm[6*W +: W] = 3'd4; dupm[7*W +: W] = 3'd4;

    #1 reset_n = 1'b0;
    #12 reset_n = 1'b1;
    cmp_en = 1'b1;

    // No table yet: requests are dropped.
    lkup_vld = '1;
    vec_vld = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    chk("lit_empty_rdy", 32'(lkup_rdy), 0);
    chk("lit_empty_rsp", 32'(rsp_vld), 0);
    lkup_vld = '0;
    vec_vld = 1'b0;

    rebuild(8'hFF, ident_map(), nb);
    chk("lit_busy_cycles", nb, 8);
    lookup(1, 5, 5, 1);

    rebuild(8'h0F, perm, nb);
    lookup(0, 0, 3, 1);
    lookup(1, 6, 0, 0);
    @(negedge clk);
    vec_vld = 1'b1; vid_vector = 8'h03;
    @(negedge clk);
    vec_vld = 1'b0;
    #1;
    chk("lit_pid_vec_vld", 32'(pid_vec_vld), 1);
    chk("lit_pid_vector", 32'(pid_vector), 32'h0C);

    rebuild(8'hFF, dupm, nb);
    chk("lit_map_err", 32'(map_err), 1);
    chk("lit_err_vid", 32'(err_vid), 4);
    lookup(0, 4, 2, 1);
    rebuild(8'hFF, ident_map(), nb);
    chk("lit_map_err_clean", 32'(map_err), 0);

    // Rebuild coincident with an accepted lookup, then a restart mid-scan.
    @(negedge clk);
    fuse_map = 8'h0F; vid_map = perm; rebuild_req = 1'b1;
    lkup_vld = 2'b01; lkup_vid[0 +: W] = 3'd5;
    @(negedge clk);
    rebuild_req = 1'b0; lkup_vld = '0;
    #1;
    chk("lit_old_rsp_vld", 32'(rsp_vld[0]), 1);
    chk("lit_old_rsp_pid", 32'(rsp_pid[0 +: W]), 5);
    chk("lit_rdy_dropped", 32'(lkup_rdy), 0);
    repeat (2) @(negedge clk);
    rebuild(8'h0F, perm, nb);
    chk("lit_restart_busy", nb, 8);

    // Asynchronous reset in the middle of a scan.
    @(negedge clk);
    fuse_map = 8'hFF; vid_map = ident_map(); rebuild_req = 1'b1;
    @(negedge clk);
    rebuild_req = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("lit_rst_busy", 32'(busy), 0);
    chk("lit_rst_valid", 32'(tbl_valid), 0);
    chk("lit_rst_rsp_pid", 32'(rsp_pid), 0);
    chk("lit_rst_mapped", 32'(rsp_mapped), 0);
    @(negedge clk);
    reset_n = 1'b1;
    lkup_vld = '1;
    repeat (5) @(negedge clk);
    lkup_vld = '0;

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      lkup_vld = P'($urandom);
      lkup_vid = (P*W)'($urandom);
      vec_vld = 1'($urandom);
      vid_vector = N'($urandom);
      fuse_map = ($urandom_range(1, 0) == 1) ? N'($urandom) : '1;
      vid_map = (N*W)'($urandom);
      rebuild_req = ($urandom_range(29, 0) == 0);
    end
    @(negedge clk);
    rebuild_req = 1'b0; lkup_vld = '0; vec_vld = 1'b0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
